// File: rtl/byte_striping_if.sv
// Byte-stream source side and lane-group publish side of the byte striper.
// The master drives the serial byte stream; the slave (the striper) drives the lanes.
interface byte_striping_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic [1:0]        lane_mode;
  logic              flush;
  logic [DATA_W-1:0] Lane_0;
  logic [DATA_W-1:0] Lane_1;
  logic [DATA_W-1:0] Lane_2;
  logic [DATA_W-1:0] Lane_3;
  logic [3:0]        lane_valid;
  logic              word_strobe;
  logic [1:0]        crt_3;
  logic              busy;

  modport master (
    output data_in, valid_in, lane_mode, flush,
    input  Lane_0, Lane_1, Lane_2, Lane_3, lane_valid, word_strobe, crt_3, busy
  );

  modport slave (
    input  data_in, valid_in, lane_mode, flush,
    output Lane_0, Lane_1, Lane_2, Lane_3, lane_valid, word_strobe, crt_3, busy
  );
endinterface

// File: rtl/byte_striping.sv
// Round-robin byte striper: stages serial bytes and publishes each complete
// (or flushed, padded) group of 1, 2 or 4 bytes atomically across the lanes.
module byte_striping #(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] PAD_BYTE = DATA_W'(8'hF7)
) (
  input logic                  clk1Mhz,
  input logic                  reset,
  byte_striping_if.slave       bus
);

  typedef enum logic {
    EMPTY,
    FILLING
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [1:0]        crt_q;
  logic [1:0]        crt_d;
  logic [1:0]        mode_q;
  logic [1:0]        eff_mode;
  logic [1:0]        last_idx;
  logic              start_group;
  logic              publish;
  logic [3:0]        mask_d;
  logic              busy_d;
  logic [DATA_W-1:0] stage_q [4];
  logic [DATA_W-1:0] group_d [4];
  logic [DATA_W-1:0] lane_q  [4];
  logic [3:0]        lane_valid_q;
  logic              strobe_q;

  // State register plus the staging, lane and mode registers it governs.
  always_ff @(posedge clk1Mhz) begin
    if (reset) begin
      state_q      <= EMPTY;
      crt_q        <= 2'd0;
      mode_q       <= 2'b10;
      strobe_q     <= 1'b0;
      lane_valid_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        stage_q[i] <= '0;
        lane_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      crt_q    <= crt_d;
      strobe_q <= publish;
      if (bus.valid_in) begin
        stage_q[crt_q] <= bus.data_in;
      end
      if (start_group) begin
        mode_q <= bus.lane_mode;
      end
      if (publish) begin
        lane_valid_q <= mask_d;
        for (int i = 0; i < 4; i++) begin
          lane_q[i] <= group_d[i];
        end
      end
    end
  end

  // The first byte of a group sizes that group from the live lane_mode,
  // so its own completion (1-lane case) must already use the new width.
  always_comb begin
    start_group = (state_q == EMPTY) && bus.valid_in;
    eff_mode    = start_group ? bus.lane_mode : mode_q;
    unique case (eff_mode)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase

    publish = (bus.valid_in && (crt_q == last_idx)) ||
              (bus.flush && (bus.valid_in || (state_q == FILLING)));

    state_d = state_q;
    crt_d   = crt_q;
    if (publish) begin
      state_d = EMPTY;
      crt_d   = 2'd0;
    end else if (bus.valid_in) begin
      state_d = FILLING;
      crt_d   = 2'(crt_q + 2'd1);
    end
  end

  // Group assembly: already-staged slots, the byte arriving this cycle,
  // padding for unfilled active slots and zero for inactive lanes.
  always_comb begin
    busy_d = (state_q == FILLING);
    unique case (eff_mode)
      2'b00:   mask_d = 4'b0001;
      2'b01:   mask_d = 4'b0011;
      default: mask_d = 4'b1111;
    endcase
    for (int i = 0; i < 4; i++) begin
      group_d[i] = '0;
      if (2'(i) <= last_idx) begin
        if (bus.valid_in && (2'(i) == crt_q)) begin
          group_d[i] = bus.data_in;
        end else if (2'(i) < crt_q) begin
          group_d[i] = stage_q[i];
        end else begin
          group_d[i] = PAD_BYTE;
        end
      end
    end
  end

  assign bus.Lane_0      = lane_q[0];
  assign bus.Lane_1      = lane_q[1];
  assign bus.Lane_2      = lane_q[2];
  assign bus.Lane_3      = lane_q[3];
  assign bus.lane_valid  = lane_valid_q;
  assign bus.word_strobe = strobe_q;
  assign bus.crt_3       = crt_q;
  assign bus.busy        = busy_d;

endmodule

// File: tb/tb_byte_striping.sv
// Directed and random stimulus for byte_striping, checked against a queue-based
// model of lane groups.
module tb_byte_striping;

  localparam logic [7:0] PAD = 8'hF7;

  logic clk1Mhz;
  logic reset;
  int   tests;
  int   failures;

  byte_striping_if #(.DATA_W(8)) bus ();

  byte_striping #(.DATA_W(8), .PAD_BYTE(PAD)) dut (
    .clk1Mhz (clk1Mhz),
    .reset   (reset),
    .bus     (bus.slave)
  );

  initial clk1Mhz = 1'b0;
  always #5 clk1Mhz = ~clk1Mhz;

  // Reference model: the open group is a queue of bytes sized by its first byte's mode.
  logic [7:0] grp_q[$];
  int         n_lat;
  logic [7:0] exp_lane [4];
  logic [3:0] exp_mask;
  logic       exp_strobe;
  logic [1:0] exp_crt;
  logic       exp_busy;

  function automatic int modeN(input logic [1:0] m);
    return (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
  endfunction

  task automatic modelStep(input logic r, input logic v, input logic [7:0] d,
                           input logic [1:0] m, input logic f);
    if (r) begin
      grp_q.delete();
      n_lat = 4;
      for (int i = 0; i < 4; i++) exp_lane[i] = 8'h00;
      exp_mask   = 4'b0000;
      exp_strobe = 1'b0;
    end else begin
      exp_strobe = 1'b0;
      if (v) begin
        if (grp_q.size() == 0) n_lat = modeN(m);
        grp_q.push_back(d);
      end
      if ((grp_q.size() == n_lat) || (f && grp_q.size() > 0)) begin
        for (int i = 0; i < 4; i++) begin
          if (i < grp_q.size()) exp_lane[i] = grp_q[i];
          else if (i < n_lat)   exp_lane[i] = PAD;
          else                  exp_lane[i] = 8'h00;
        end
        exp_mask   = 4'((1 << n_lat) - 1);
        exp_strobe = 1'b1;
        grp_q.delete();
      end
    end
    exp_crt  = 2'(grp_q.size());
    exp_busy = (grp_q.size() != 0);
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    checkVal("Lane_0", 32'(bus.Lane_0), 32'(exp_lane[0]));
    checkVal("Lane_1", 32'(bus.Lane_1), 32'(exp_lane[1]));
    checkVal("Lane_2", 32'(bus.Lane_2), 32'(exp_lane[2]));
    checkVal("Lane_3", 32'(bus.Lane_3), 32'(exp_lane[3]));
    checkVal("lane_valid", 32'(bus.lane_valid), 32'(exp_mask));
    checkVal("word_strobe", 32'(bus.word_strobe), 32'(exp_strobe));
    checkVal("crt_3", 32'(bus.crt_3), 32'(exp_crt));
    checkVal("busy", 32'(bus.busy), 32'(exp_busy));
  endtask

  // Drives one cycle of inputs, advances the model and checks #1 after the edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d,
                               input logic [1:0] m, input logic f);
    reset         = r;
    bus.valid_in  = v;
    bus.data_in   = d;
    bus.lane_mode = m;
    bus.flush     = f;
    @(posedge clk1Mhz);
    modelStep(r, v, d, m, f);
    #1;
    checkOutput();
  endtask

  initial begin
    tests         = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.valid_in  = 1'b0;
    bus.data_in   = 8'h00;
    bus.lane_mode = 2'b10;
    bus.flush     = 1'b0;
    #2;

    applyStimulus(1, 0, 8'h00, 2'b10, 0);
    applyStimulus(1, 1, 8'hFF, 2'b00, 1);
    applyStimulus(0, 0, 8'h00, 2'b10, 0);

    // 4-lane stream 00..07
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 8'(i), 2'b10, 0);
    checkVal("t1_lane3", 32'(bus.Lane_3), 32'h07);
    checkVal("t1_mask", 32'(bus.lane_valid), 32'hF);
    applyStimulus(0, 0, 8'h00, 2'b10, 0);

    // 2-lane with gaps
    applyStimulus(0, 1, 8'hAA, 2'b01, 0);
    applyStimulus(0, 0, 8'h00, 2'b01, 0);
    applyStimulus(0, 1, 8'hBB, 2'b01, 0);
    checkVal("t2_lane1", 32'(bus.Lane_1), 32'hBB);
    applyStimulus(0, 0, 8'h00, 2'b01, 0);
    applyStimulus(0, 1, 8'hCC, 2'b01, 0);
    applyStimulus(0, 0, 8'h00, 2'b01, 0);
    applyStimulus(0, 1, 8'hDD, 2'b01, 0);
    checkVal("t2_mask", 32'(bus.lane_valid), 32'h3);
    applyStimulus(0, 0, 8'h00, 2'b01, 0);

    // Flush alone, then flush in EMPTY
    applyStimulus(0, 1, 8'h11, 2'b10, 0);
    applyStimulus(0, 1, 8'h22, 2'b10, 0);
    applyStimulus(0, 1, 8'h33, 2'b10, 0);
    applyStimulus(0, 0, 8'h00, 2'b10, 1);
    checkVal("t3_pad", 32'(bus.Lane_3), 32'hF7);
    checkVal("t3_strobe", 32'(bus.word_strobe), 32'h1);
    applyStimulus(0, 0, 8'h00, 2'b10, 1);
    checkVal("t3_nostrobe", 32'(bus.word_strobe), 32'h0);

    // Byte with flush in the same cycle
    applyStimulus(0, 1, 8'h11, 2'b10, 0);
    applyStimulus(0, 1, 8'h22, 2'b10, 0);
    applyStimulus(0, 1, 8'h33, 2'b10, 1);
    checkVal("t4_lane2", 32'(bus.Lane_2), 32'h33);
    checkVal("t4_lane3", 32'(bus.Lane_3), 32'hF7);
    applyStimulus(0, 0, 8'h00, 2'b10, 0);

    // Reset discards partial group
    applyStimulus(0, 1, 8'h11, 2'b10, 0);
    applyStimulus(0, 1, 8'h22, 2'b10, 0);
    applyStimulus(1, 0, 8'h00, 2'b10, 0);
    checkVal("t5_rst_lane0", 32'(bus.Lane_0), 32'h00);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'(8'h40 + i), 2'b10, 0);
    checkVal("t5_lane0", 32'(bus.Lane_0), 32'h40);

    // Mode change mid-group is deferred
    applyStimulus(0, 1, 8'h01, 2'b10, 0);
    applyStimulus(0, 1, 8'h02, 2'b00, 0);
    applyStimulus(0, 1, 8'h03, 2'b00, 0);
    applyStimulus(0, 1, 8'h04, 2'b00, 0);
    checkVal("t6_lane3", 32'(bus.Lane_3), 32'h04);
    applyStimulus(0, 1, 8'h05, 2'b00, 0);
    checkVal("t6_lane0", 32'(bus.Lane_0), 32'h05);
    checkVal("t6_mask", 32'(bus.lane_valid), 32'h1);
    checkVal("t6_lane1", 32'(bus.Lane_1), 32'h00);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 65),
                    8'($urandom),
                    2'($urandom),
                    ($urandom_range(0, 99) < 12));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
